fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be a power of two, 2..16.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, instruction word presented on pop_instr while the queue is empty.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 push_valid  in  1  fetch stage offers an entry this cycle.
REQ-006 push_instr  in  32 (DATA_BUS)  fetched instruction word.
REQ-007 push_pc  in  32 (DATA_BUS)  PC of the fetched instruction.
REQ-008 push_ready  out  1  queue accepts an entry this cycle.
REQ-009 pop_valid  out  1  head entry is valid for the decode stage.
REQ-010 pop_instr  out  32 (DATA_BUS)  head instruction word.
REQ-011 pop_pc  out  32 (DATA_BUS)  head PC.
REQ-012 pop_pcplus4  out  32 (DATA_BUS)  head PC + 4.
REQ-013 pop_ready  in  1  decode stage consumes the head this cycle.
REQ-014 flush  in  1  redirect (taken branch/jump); discards all entries.
REQ-015 count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries, each holding {instr, pc}, with read pointer, write pointer and occupancy counter.
REQ-017 Push fires when push_valid && push_ready at a rising edge: write entry at write pointer, advance write pointer modulo DEPTH.
REQ-018 Pop fires when pop_valid && pop_ready at a rising edge: advance read pointer modulo DEPTH.
REQ-019 push_ready SHALL be 1 iff count < DEPTH and rst is low; it SHALL NOT depend combinationally on pop_ready (no pass-through when full).
REQ-020 pop_valid SHALL be 1 iff count > 0.
REQ-021 Pop outputs SHALL be show-ahead: pop_instr/pop_pc are driven combinationally from the entry at the read pointer.
REQ-022 Latency: an entry pushed at edge N SHALL appear on the pop outputs after edge N (one cycle); no same-cycle bypass from push to pop.
REQ-023 When count == 0: pop_instr = NOP_INSTR, pop_pc = 32'h0, pop_pcplus4 = 32'h4.
REQ-024 pop_pcplus4 = pop_pc + 4 modulo 2^32 (32'hFFFFFFFC yields 32'h0).
REQ-025 Simultaneous push and pop with 0 < count < DEPTH: both fire, count unchanged.
REQ-026 Push with count == DEPTH: push_ready is 0, entry not taken, even if pop fires in the same cycle.
REQ-027 Pop with count == 0: pop_valid is 0, no pointer movement; a push in the same cycle still fires.
REQ-028 flush SHALL take priority over push and pop: at that edge count, read and write pointers become 0; any concurrent push is discarded.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 without disturbing stored data or count.
REQ-030 count SHALL equal (pushes - pops) since the last reset or flush, never exceeding DEPTH and never going below 0.

Reset
REQ-031 rst asserted SHALL immediately, independent of clk, set count = 0, both pointers = 0, pop_valid = 0, push_ready = 0, pop_instr = NOP_INSTR, pop_pc = 0, pop_pcplus4 = 4.
REQ-032 Storage contents need not be reset; they SHALL NOT be observable while count == 0.
REQ-033 On rst deassertion push_ready SHALL rise combinationally; the first push is accepted at the first rising edge with rst low.
REQ-034 Reset mid-operation SHALL discard all entries; no push or pop fires at an edge where rst is high.

Verification
REQ-035 Reset, then push 0x00500093 @pc 0x0, with pop_ready=0 -> after edge pop_valid=1, pop_instr=0x00500093, pop_pc=0x0, pop_pcplus4=0x4, count=1.
REQ-036 Push 4 entries (pc 0x0,0x4,0x8,0xC), pop_ready=0 -> count=4, push_ready=0; 5th push (pc 0x10) ignored; pop four times yields pc 0x0,0x4,0x8,0xC in order, then pop_instr=0x00000013.
REQ-037 count=2, push and pop each cycle for 10 cycles -> count stays 2, pops in strict push order across pointer wrap.
REQ-038 count=3, flush with push_valid=1 -> after edge count=0, pop_valid=0, push_ready=1; next push appears as sole entry.
REQ-039 Push pc 0xFFFFFFFC -> pop_pcplus4 = 0x00000000.
REQ-040 count=2, assert rst between clock edges -> count=0, pop_valid=0, push_ready=0 before the next edge; deassert -> push_ready=1.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of {instr, pc}
// entries with show-ahead pop outputs and flush-on-redirect.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_pc,
  output logic                     push_ready,
  output logic                     pop_valid,
  output logic [31:0]              pop_instr,
  output logic [31:0]              pop_pc,
  output logic [31:0]              pop_pcplus4,
  input  logic                     pop_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_fire, pop_fire;
  entry_t          head;

  // Handshakes: push_ready looks only at occupancy, never at pop_ready,
  // so a full queue never accepts an entry even when the head drains.
  assign push_ready = !rst && (count_q < CW'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  // Show-ahead head; an empty queue presents a NOP at pc 0 so stale
  // storage is never visible.
  assign head        = mem_q[rd_ptr_q];
  assign pop_instr   = pop_valid ? head.instr : NOP_INSTR;
  assign pop_pc      = pop_valid ? head.pc    : 32'h0;
  assign pop_pcplus4 = pop_pc + 32'd4;
  assign count       = count_q;

  // Next-state: flush wins over push/pop; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        mem_d[wr_ptr_q] = '{instr: push_instr, pc: push_pc};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: no reset needed, contents hidden while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based scoreboard model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [31:0] push_instr = '0;
  logic [31:0] push_pc = '0;
  logic        push_ready;
  logic        pop_valid;
  logic [31:0] pop_instr, pop_pc, pop_pcplus4;
  logic        pop_ready = 1'b0;
  logic        flush = 1'b0;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   total  = 0;
  int   passes = 0;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_instr(push_instr), .push_pc(push_pc),
    .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_instr(pop_instr), .pop_pc(pop_pc),
    .pop_pcplus4(pop_pcplus4), .pop_ready(pop_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    mk = '{instr: 32'hA500_0013 ^ (pc << 4), pc: pc};
  endfunction

  // Everything visible while rst is held high.
  task automatic chk_reset(input string tag);
    chk({tag, " count"},      32'(count),           32'd0);
    chk({tag, " pop_valid"},  {31'b0, pop_valid},   32'd0);
    chk({tag, " push_ready"}, {31'b0, push_ready},  32'd0);
    chk({tag, " pop_instr"},  pop_instr,            NOP);
    chk({tag, " pop_pc"},     pop_pc,               32'h0);
    chk({tag, " pcplus4"},    pop_pcplus4,          32'h4);
  endtask

  // Compare every output against the scoreboard model (rst low).
  task automatic check_head(input string tag);
    if (sb.size() == 0) begin
      chk({tag, " nop instr"}, pop_instr,   NOP);
      chk({tag, " nop pc"},    pop_pc,      32'h0);
      chk({tag, " nop pc4"},   pop_pcplus4, 32'h4);
    end else begin
      chk({tag, " instr"}, pop_instr,   sb[0].instr);
      chk({tag, " pc"},    pop_pc,      sb[0].pc);
      chk({tag, " pc4"},   pop_pcplus4, sb[0].pc + 32'd4);
    end
    chk({tag, " pop_valid"},  {31'b0, pop_valid},  {31'b0, sb.size() != 0});
    chk({tag, " push_ready"}, {31'b0, push_ready}, {31'b0, sb.size() < DEPTH});
    chk({tag, " count"},      32'(count),          32'(sb.size()));
  endtask

  // One clock of stimulus; the model decides acceptance from the
  // pre-edge occupancy, then outputs are checked after the edge.
  task automatic cycle(input string tag, input bit pv, input logic [31:0] pc,
                       input bit pr, input bit fl);
    ent_t e;
    ent_t tmp;
    bit   acc;
    e          = mk(pc);
    push_valid = pv;
    push_instr = e.instr;
    push_pc    = pc;
    pop_ready  = pr;
    flush      = fl;
    #1;
    acc = pv && (sb.size() < DEPTH);
    if (fl) sb.delete();
    else begin
      if (pr && sb.size() > 0) tmp = sb.pop_front();
      if (acc) sb.push_back(e);
    end
    @(posedge clk); #1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    check_head(tag);
  endtask

  initial begin
    // reset state, asynchronous before any edge
    #3;
    chk_reset("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst release push_ready", {31'b0, push_ready}, 32'd1);
    check_head("idle");

    // single push, no pop: visible one edge later
    cycle("push1", 1, 32'h0, 0, 0);
    chk("push1 literal instr", pop_instr, 32'hA500_0013);
    cycle("pop1", 0, 32'h0, 1, 0);

    // fill to DEPTH, overfill, push+pop while full, drain
    for (int i = 0; i < 4; i++) cycle("fill", 1, 32'(4 * i), 0, 0);
    chk("full count", 32'(count), 32'd4);
    cycle("overfill", 1, 32'h10, 0, 0);
    cycle("full pushpop", 1, 32'h14, 1, 0);
    for (int i = 0; i < 3; i++) cycle("drain", 0, 32'h0, 1, 0);
    chk("drained nop", pop_instr, 32'h0000_0013);

    // steady state at count 2 across pointer wrap
    cycle("pre2a", 1, 32'h1000, 0, 0);
    cycle("pre2b", 1, 32'h1004, 0, 0);
    for (int i = 0; i < 10; i++) cycle("steady", 1, 32'(32'h2000 + 4 * i), 1, 0);
    cycle("drain2a", 0, 32'h0, 1, 0);
    cycle("drain2b", 0, 32'h0, 1, 0);

    // pop on empty with concurrent push: only the push fires
    cycle("empty pushpop", 1, 32'h3000, 1, 0);

    // flush at count 3 with a concurrent push
    cycle("f2", 1, 32'h3004, 0, 0);
    cycle("f3", 1, 32'h3008, 0, 0);
    chk("pre-flush count", 32'(count), 32'd3);
    cycle("flush", 1, 32'h300C, 0, 1);
    cycle("post-flush push", 1, 32'h4000, 0, 0);
    cycle("post-flush pop", 0, 32'h0, 1, 0);

    // pc + 4 wraps to zero
    cycle("wrap pc", 1, 32'hFFFF_FFFC, 0, 0);
    chk("wrap pc4", pop_pcplus4, 32'h0);
    cycle("wrap pop", 0, 32'h0, 1, 0);

    // asynchronous reset mid-cycle with two entries held
    cycle("r1", 1, 32'h100, 0, 0);
    cycle("r2", 1, 32'h104, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    push_valid = 1'b1;
    push_instr = 32'hDEAD_BEEF;
    push_pc    = 32'h500;
    @(posedge clk); #1;
    chk_reset("rst edge");
    sb.delete();
    push_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst deassert push_ready", {31'b0, push_ready}, 32'd1);
    check_head("after midrst");
    cycle("after rst push", 1, 32'h600, 0, 0);
    cycle("after rst pop", 0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
